// File: rtl/soc_reset_pkg.sv
// soc_reset_pkg: state encoding, reset-cause codes and a saturating-count helper
// shared by the reset sequencer and its testbench.
`default_nettype none

package soc_reset_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_SW  = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/soc_wdt.sv
// soc_wdt: watchdog that pulses expire after WDT_CYCLES consecutive enabled
// cycles without a kick; the count clears whenever enable drops.
`default_nettype none

module soc_wdt #(
  parameter int WDT_CYCLES = 2000,
  parameter int CNT_W      = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic kick,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Expiry is evaluated against the current edge, so a kick on that same edge wins.
  assign expire = enable && !kick && (cnt_q == CNT_W'(WDT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!enable || kick || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/soc_reset_seq.sv
// soc_reset_seq: staggered multi-channel reset sequencer with SW request and an
// optional watchdog (enabled by defining SOC_RST_WDT_EN).
`default_nettype none

module soc_reset_seq
  import soc_reset_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int RST_CYCLES = 10,
  parameter int STAGGER    = 4,
  parameter int WDT_CYCLES = 2000,
  parameter int CNT_W      = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           sw_req,
  input  logic           wdt_kick,
  output logic [NCH-1:0] rst_out,
  output logic           ready,
  output logic [1:0]     cause,
  output logic [7:0]     reset_count
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NCH-1:0]   rst_q, rst_d;
  logic             ready_q, ready_d;
  logic [1:0]       cause_q, cause_d;
  logic [7:0]       count_q, count_d;
  logic             wdt_expire;
  logic             rst_evt;
  logic [1:0]       evt_cause;

`ifdef SOC_RST_WDT_EN
  soc_wdt #(
    .WDT_CYCLES (WDT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_wdt (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (state_q == ST_RUN),
    .kick    (wdt_kick),
    .expire  (wdt_expire)
  );
`else
  logic unused_kick;
  assign unused_kick = wdt_kick;
  assign wdt_expire  = 1'b0;
`endif

  // SW request outranks a simultaneous watchdog expiry.
  always_comb begin
    rst_evt   = 1'b0;
    evt_cause = CAUSE_SW;
    if (sw_req) begin
      rst_evt   = 1'b1;
      evt_cause = CAUSE_SW;
    end else if (wdt_expire) begin
      rst_evt   = 1'b1;
      evt_cause = CAUSE_WDT;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;
    count_d = count_q;

    if (rst_evt) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      cause_d = evt_cause;
      count_d = sat_inc(count_q);
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            cnt_d    = '0;
            rst_d[0] = 1'b0;
            if (NCH == 1) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == CNT_W'(STAGGER - 1)) begin
            cnt_d        = '0;
            rst_d[idx_q] = 1'b0;
            if (idx_q == IDX_W'(NCH - 1)) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          rst_d   = '0;
          ready_d = 1'b1;
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_POR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  assign rst_out     = rst_q;
  assign ready       = ready_q;
  assign cause       = cause_q;
  assign reset_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_soc_reset_seq.sv
// tb_soc_reset_seq: table-driven vectors plus directed sequences for the
// staggered reset sequencer (NCH=2, RST_CYCLES=10, STAGGER=4, WDT_CYCLES=50).
`default_nettype none

module tb_soc_reset_seq;

  logic       clock;
  logic       reset_n;
  logic       sw_req;
  logic       wdt_kick;
  logic [1:0] rst_out;
  logic       ready;
  logic [1:0] cause;
  logic [7:0] reset_count;

  int n_vec;
  int n_bad;

  typedef struct {
    logic       sw;
    logic       kick;
    logic [1:0] e_rst;
    logic       e_rdy;
    logic [1:0] e_cause;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [30];

  soc_reset_seq #(
    .NCH        (2),
    .RST_CYCLES (10),
    .STAGGER    (4),
    .WDT_CYCLES (50),
    .CNT_W      (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sw_req      (sw_req),
    .wdt_kick    (wdt_kick),
    .rst_out     (rst_out),
    .ready       (ready),
    .cause       (cause),
    .reset_count (reset_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected rst_out k edges after entry into ASSERT.
  function automatic logic [1:0] exp_rst(input int k);
    if (k < 10) return 2'b11;
    if (k < 14) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [1:0] er, input logic erdy,
                     input logic [1:0] ec, input logic [7:0] ecnt);
    n_vec++;
    if (rst_out !== er || ready !== erdy || cause !== ec || reset_count !== ecnt) begin
      n_bad++;
      $display("FAIL %s @%0t: got rst=%b rdy=%b cause=%0d cnt=%0d, want rst=%b rdy=%b cause=%0d cnt=%0d",
               nm, $time, rst_out, ready, cause, reset_count, er, erdy, ec, ecnt);
    end
  endtask

  // Called at a falling edge; applies inputs across one rising edge.
  task automatic step(input logic sw, input logic kick);
    sw_req   = sw;
    wdt_kick = kick;
    @(posedge clock);
    @(negedge clock);
    sw_req   = 1'b0;
    wdt_kick = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("por_async", 2'b11, 1'b0, 2'd0, 8'd0);
    repeat (3) @(negedge clock);
    chk("por_held", 2'b11, 1'b0, 2'd0, 8'd0);
    reset_n = 1'b1;
  endtask

  task automatic seq_check(input string nm, input logic [1:0] ec, input logic [7:0] ecnt);
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 1'b0);
      chk(nm, exp_rst(k), (k >= 14), ec, ecnt);
    end
  endtask

  task automatic run_hold(input string nm, input int n, input logic [1:0] ec, input logic [7:0] ecnt);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0);
      chk(nm, 2'b00, 1'b1, ec, ecnt);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    reset_n  = 1'b0;
    sw_req   = 1'b0;
    wdt_kick = 1'b0;

    // Power-on sequence, one RUN cycle, SW pulse, restarted sequence.
    for (int i = 0; i < 14; i++)
      tbl[i] = '{1'b0, 1'b0, exp_rst(i + 1), (i + 1 >= 14), 2'd0, 8'd0};
    tbl[14] = '{1'b0, 1'b1, 2'b00, 1'b1, 2'd0, 8'd0};
    tbl[15] = '{1'b1, 1'b0, 2'b11, 1'b0, 2'd1, 8'd1};
    for (int i = 16; i < 30; i++)
      tbl[i] = '{1'b0, 1'b0, exp_rst(i - 15), (i - 15 >= 14), 2'd1, 8'd1};

    @(negedge clock);
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step(tbl[i].sw, tbl[i].kick);
      chk($sformatf("tbl[%0d]", i), tbl[i].e_rst, tbl[i].e_rdy, tbl[i].e_cause, tbl[i].e_cnt);
    end

    // Kicked RUN for 500 cycles, then a SW pulse from a fresh POR.
    do_reset();
    seq_check("por_seq", 2'd0, 8'd0);
    for (int c = 0; c < 500; c++) begin
      step(1'b0, (c % 20) == 19);
      chk("kick_run", 2'b00, 1'b1, 2'd0, 8'd0);
    end
    step(1'b1, 1'b0);
    chk("sw_from_run", 2'b11, 1'b0, 2'd1, 8'd1);
    seq_check("sw_seq", 2'd1, 8'd1);

`ifdef SOC_RST_WDT_EN
    run_hold("wdt_pre", 49, 2'd1, 8'd1);
    step(1'b0, 1'b0);
    chk("wdt_fire", 2'b11, 1'b0, 2'd2, 8'd2);
    seq_check("wdt_seq", 2'd2, 8'd2);
    run_hold("wdt_pre2", 49, 2'd2, 8'd2);
    step(1'b0, 1'b1);
    chk("wdt_kick_wins", 2'b00, 1'b1, 2'd2, 8'd2);
    run_hold("wdt_pre3", 49, 2'd2, 8'd2);
    step(1'b1, 1'b0);
    chk("wdt_sw_tie", 2'b11, 1'b0, 2'd1, 8'd3);
    seq_check("tie_seq", 2'd1, 8'd3);
`else
    run_hold("no_wdt", 1000, 2'd1, 8'd1);
`endif

    // SW request mid-RELEASE.
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      step(1'b0, 1'b0);
      chk("mid_pre", exp_rst(k), 1'b0, 2'd0, 8'd0);
    end
    step(1'b1, 1'b0);
    chk("mid_sw", 2'b11, 1'b0, 2'd1, 8'd1);
    seq_check("mid_seq", 2'd1, 8'd1);

    // Asynchronous reset mid-RELEASE clears the count.
    step(1'b1, 1'b0);
    chk("pre_async_sw", 2'b11, 1'b0, 2'd1, 8'd2);
    for (int k = 1; k <= 11; k++) begin
      step(1'b0, 1'b0);
      chk("pre_async", exp_rst(k), 1'b0, 2'd1, 8'd2);
    end
    do_reset();
    seq_check("async_seq", 2'd0, 8'd0);

    // Saturation of reset_count.
    for (int k = 1; k <= 300; k++) begin
      step(1'b1, 1'b0);
      chk("sat", 2'b11, 1'b0, 2'd1, (k > 255) ? 8'd255 : 8'(k));
    end
    seq_check("sat_seq", 2'd1, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
